mux_n_sel_reg: RTL and testbench



---
 rtl/mux_n_sel_reg.sv | 128 ++++++++++++
 tb/tb_mux_n_sel_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux_n_sel_reg.sv
// Registered N:1 valid/ready selector, 1-cycle latency, full throughput; R is held low while Y is stalled (YV && !YR).
// MODE=1 arbitration is round-robin when MUX_SEL_RR_EN is defined, otherwise fixed lowest-index priority.
module mux_n_sel_reg #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] D,
  input  logic [N-1:0]   V,
  output logic [N-1:0]   R,
  input  logic [SW-1:0]  S,
  input  logic           MODE,
  output logic [W-1:0]   Y,
  output logic           YV,
  input  logic           YR,
  output logic [SW-1:0]  GNT
);

  logic [W-1:0]  y_q, y_d;
  logic          yv_q, yv_d;
  logic [SW-1:0] gnt_q, gnt_d;
  logic          load_en;
  logic          cand_vld;
  logic [SW-1:0] cand_idx;
  logic [W-1:0]  sel_dat;
  logic [N-1:0]  rdy;

`ifdef MUX_SEL_RR_EN
  logic [SW-1:0] ptr_q, ptr_d;
  int            j;
`endif

  assign load_en = !yv_q || YR;

  // An out-of-range S matches no channel index, so it can never grant.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
`ifdef MUX_SEL_RR_EN
    j = 0;
`endif
    if (!MODE) begin
      for (int i = 0; i < N; i++) begin
        if (!cand_vld && S == SW'(i) && V[i]) begin
          cand_vld = 1'b1;
          cand_idx = SW'(i);
        end
      end
    end else begin
`ifdef MUX_SEL_RR_EN
      for (int k = 0; k < N; k++) begin
        j = int'(ptr_q) + k;
        if (j >= N) j = j - N;
        if (!cand_vld && V[j]) begin
          cand_vld = 1'b1;
          cand_idx = SW'(j);
        end
      end
`else
      for (int k = 0; k < N; k++) begin
        if (!cand_vld && V[k]) begin
          cand_vld = 1'b1;
          cand_idx = SW'(k);
        end
      end
`endif
    end
  end

  // Ready and data muxes are kept separate so D never reaches R.
  always_comb begin
    rdy     = '0;
    sel_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_idx == SW'(i)) begin
        rdy[i]  = rst_n && load_en && cand_vld;
        sel_dat = D[i*W +: W];
      end
    end
  end

  always_comb begin
    y_d   = y_q;
    yv_d  = yv_q;
    gnt_d = gnt_q;
`ifdef MUX_SEL_RR_EN
    ptr_d = ptr_q;
`endif
    if (load_en) begin
      if (cand_vld) begin
        y_d   = sel_dat;
        yv_d  = 1'b1;
        gnt_d = cand_idx;
`ifdef MUX_SEL_RR_EN
        if (MODE) ptr_d = (cand_idx == SW'(N-1)) ? '0 : cand_idx + 1'b1;
`endif
      end else begin
        yv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      yv_q  <= 1'b0;
      gnt_q <= '0;
`ifdef MUX_SEL_RR_EN
      ptr_q <= '0;
`endif
    end else begin
      y_q   <= y_d;
      yv_q  <= yv_d;
      gnt_q <= gnt_d;
`ifdef MUX_SEL_RR_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  assign R   = rdy;
  assign Y   = y_q;
  assign YV  = yv_q;
  assign GNT = gnt_q;

endmodule

// File: tb/tb_mux_n_sel_reg.sv
// Directed bench for mux_n_sel_reg: main N=4/W=8 instance plus N=16/W=1 and N=3/W=4 edge instances.
module tb_mux_n_sel_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Main instance
  logic [31:0] d;
  logic [3:0]  v, r;
  logic [1:0]  s, gnt;
  logic        mode, yv, yr;
  logic [7:0]  y;

  mux_n_sel_reg #(.N(4), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .D(d), .V(v), .R(r), .S(s), .MODE(mode),
    .Y(y), .YV(yv), .YR(yr), .GNT(gnt)
  );

  // Wide-select edge instance
  logic [15:0] d1, v1, r1;
  logic [3:0]  s1, gnt1;
  logic        mode1, yv1, yr1;
  logic [0:0]  y1;

  mux_n_sel_reg #(.N(16), .W(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .D(d1), .V(v1), .R(r1), .S(s1), .MODE(mode1),
    .Y(y1), .YV(yv1), .YR(yr1), .GNT(gnt1)
  );

  // Non-power-of-two edge instance
  logic [11:0] d2;
  logic [2:0]  v2, r2;
  logic [1:0]  s2, gnt2;
  logic        mode2, yv2, yr2;
  logic [3:0]  y2;

  mux_n_sel_reg #(.N(3), .W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .D(d2), .V(v2), .R(r2), .S(s2), .MODE(mode2),
    .Y(y2), .YV(yv2), .YR(yr2), .GNT(gnt2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    d = {8'h44, 8'h33, 8'h22, 8'h11};
    v = 4'b1111; s = 2'd2; mode = 1'b0; yr = 1'b1;
    d1 = '0; v1 = '0; s1 = '0; mode1 = 1'b0; yr1 = 1'b1;
    d2 = '0; v2 = '0; s2 = '0; mode2 = 1'b0; yr2 = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (yv !== 1'b0) begin errors++; $display("FAIL reset_yv got=%b exp=0", yv); end
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y got=%h exp=00", y); end
    checks++; if (gnt !== 2'd0) begin errors++; $display("FAIL reset_gnt got=%0d exp=0", gnt); end
    checks++; if (r !== 4'b0000) begin errors++; $display("FAIL reset_r got=%b exp=0000", r); end
    step(); step();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_mode0;
    d = {8'h44, 8'h33, 8'h22, 8'h11};
    v = 4'b1111; s = 2'd2; mode = 1'b0; yr = 1'b1;
    #1;
    checks++; if (r !== 4'b0100) begin errors++; $display("FAIL m0_r got=%b exp=0100", r); end
    step();
    checks++; if (y !== 8'h33) begin errors++; $display("FAIL m0_y got=%h exp=33", y); end
    checks++; if (gnt !== 2'd2) begin errors++; $display("FAIL m0_gnt got=%0d exp=2", gnt); end
    checks++; if (yv !== 1'b1) begin errors++; $display("FAIL m0_yv got=%b exp=1", yv); end
    s = 2'd3; v = 4'b0111;
    #1;
    checks++; if (r !== 4'b0000) begin errors++; $display("FAIL m0_nocand_r got=%b exp=0000", r); end
    step();
    checks++; if (yv !== 1'b0) begin errors++; $display("FAIL m0_nocand_yv got=%b exp=0", yv); end
    checks++; if (y !== 8'h33 || gnt !== 2'd2) begin
      errors++; $display("FAIL m0_hold got y=%h gnt=%0d exp y=33 gnt=2", y, gnt);
    end
  endtask

  task automatic test_arb;
`ifdef MUX_SEL_RR_EN
    logic [1:0] exp_g [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3};
`else
    logic [1:0] exp_g [9] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
`endif
    logic [7:0] exp_y;
    mode = 1'b1; yr = 1'b1;
`ifdef MUX_SEL_RR_EN
    v = 4'b1111;
`else
    v = 4'b1110;
`endif
    for (int i = 0; i < 9; i++) begin
`ifdef MUX_SEL_RR_EN
      if (i == 5) v = 4'b1010;
`else
      if (i == 5) v = 4'b1100;
`endif
      step();
      exp_y = 8'h11 * (8'(exp_g[i]) + 8'd1);
      checks++;
      if (gnt !== exp_g[i] || y !== exp_y || yv !== 1'b1) begin
        errors++;
        $display("FAIL arb_%0d got gnt=%0d y=%h yv=%b exp gnt=%0d y=%h yv=1", i, gnt, y, yv, exp_g[i], exp_y);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] vpat [3] = '{4'b1111, 4'b0000, 4'b1111};
    mode = 1'b0; s = 2'd0; v = 4'b1111; yr = 1'b1;
    step();
    yr = 1'b0; s = 2'd1;
    for (int i = 0; i < 3; i++) begin
      v = vpat[i];
      #1;
      checks++; if (r !== 4'b0000) begin errors++; $display("FAIL bp_r_%0d got=%b exp=0000", i, r); end
      step();
      checks++;
      if (y !== 8'h11 || gnt !== 2'd0 || yv !== 1'b1) begin
        errors++; $display("FAIL bp_hold_%0d got y=%h gnt=%0d yv=%b exp y=11 gnt=0 yv=1", i, y, gnt, yv);
      end
    end
    yr = 1'b1; v = 4'b1111;
    #1;
    checks++; if (r !== 4'b0010) begin errors++; $display("FAIL bp_release_r got=%b exp=0010", r); end
    step();
    checks++;
    if (y !== 8'h22 || gnt !== 2'd1 || yv !== 1'b1) begin
      errors++; $display("FAIL bp_nobubble got y=%h gnt=%0d yv=%b exp y=22 gnt=1 yv=1", y, gnt, yv);
    end
  endtask

  task automatic test_reset_mid;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (yv !== 1'b0 || y !== 8'h00 || gnt !== 2'd0 || r !== 4'b0000) begin
      errors++; $display("FAIL rst_mid got yv=%b y=%h gnt=%0d r=%b exp 0/00/0/0000", yv, y, gnt, r);
    end
    @(negedge clk) rst_n = 1'b1;
    mode = 1'b0; s = 2'd3; v = 4'b1111; yr = 1'b1;
    step();
    checks++;
    if (y !== 8'h44 || gnt !== 2'd3 || yv !== 1'b1) begin
      errors++; $display("FAIL rst_first_grant got y=%h gnt=%0d yv=%b exp y=44 gnt=3 yv=1", y, gnt, yv);
    end
  endtask

  task automatic test_edges;
    d1 = 16'h8000; v1 = 16'hffff; s1 = 4'd15;
    d2 = {4'hC, 4'hB, 4'hA}; v2 = 3'b111; s2 = 2'd3;
    #1;
    checks++; if (r1 !== 16'h8000) begin errors++; $display("FAIL n16_r got=%h exp=8000", r1); end
    checks++; if (r2 !== 3'b000) begin errors++; $display("FAIL n3_oor_r got=%b exp=000", r2); end
    step();
    checks++;
    if (y1 !== 1'b1 || gnt1 !== 4'd15 || yv1 !== 1'b1) begin
      errors++; $display("FAIL n16_top got y=%b gnt=%0d yv=%b exp y=1 gnt=15 yv=1", y1, gnt1, yv1);
    end
    checks++; if (yv2 !== 1'b0) begin errors++; $display("FAIL n3_oor_yv got=%b exp=0", yv2); end
    s1 = 4'd14; s2 = 2'd2;
    #1;
    checks++; if (r2 !== 3'b100) begin errors++; $display("FAIL n3_r got=%b exp=100", r2); end
    step();
    checks++;
    if (y1 !== 1'b0 || gnt1 !== 4'd14) begin
      errors++; $display("FAIL n16_s14 got y=%b gnt=%0d exp y=0 gnt=14", y1, gnt1);
    end
    checks++;
    if (y2 !== 4'hC || gnt2 !== 2'd2 || yv2 !== 1'b1) begin
      errors++; $display("FAIL n3_top got y=%h gnt=%0d yv=%b exp y=C gnt=2 yv=1", y2, gnt2, yv2);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_arb();
    test_backpressure();
    test_reset_mid();
    test_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
